// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V front end: datapath width, canonical NOP
// encoding, default reset PC and the {pc, inst} entry that travels from fetch
// to decode.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO used twice in the fetch stage: once for the PCs of
// in-flight memory requests and once for returned {pc, word} entries.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write din at the tail (caller guarantees not full)
//   pop         drop the head entry (caller guarantees not empty)
//   flush       empty the FIFO; overrides push and pop in the same cycle
//   dout        head entry (undefined while empty)
//   count       number of valid entries, 0..DEPTH
//   full/empty  count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; validity is carried entirely by
  // count, so resetting the data would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Holds the PC, issues word reads to instruction
// memory (in-order responses, variable latency), buffers returned words and
// hands {inst_pc, inst_code} to decode over valid/ready. A redirect from
// execute flushes the buffer and marks every still-outstanding response as
// stale so it is discarded on arrival.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         fetch request and word-aligned address
//   imem_ready                 memory accepts the request this cycle
//   imem_rvalid/imem_rdata     in-order response
//   redirect_valid/redirect_pc one-cycle redirect; redirect_pc[1:0] ignored
//   inst_valid/inst_code/inst_pc/inst_ready  decode handshake
// -----------------------------------------------------------------------------
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_code,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [XLEN-1:0] pcq_head;
  logic [CW-1:0]   pcq_count;
  logic            pcq_full;
  logic            pcq_empty;

  fetch_entry_t    buf_in;
  fetch_entry_t    buf_head;
  logic [CW-1:0]   buf_count;
  logic            buf_full;
  logic            buf_empty;

  logic            accept;
  logic            keep;
  logic            xfer;
  logic [OW-1:0]   occupancy;
  logic            credit;

  assign inst_valid = !buf_empty;

  // A redirect flushes the buffer, so nothing is handed to decode that cycle.
  assign xfer = inst_valid && inst_ready && !redirect_valid;

  // A buffer slot freed by this cycle's transfer counts as free credit; without
  // this, DEPTH = 2 could not sustain one instruction per cycle.
  assign occupancy = OW'(outstanding) + OW'(buf_count) - OW'(xfer);
  assign credit    = (occupancy < OW'(DEPTH));

  assign imem_req  = rst_n && credit && !redirect_valid;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign keep = imem_rvalid && (drop_cnt == '0) && !redirect_valid;

  assign buf_in = '{pc: pcq_head, inst: imem_rdata};

  // Head storage is unreset; present zeros while empty.
  assign inst_code = inst_valid ? buf_head.inst : '0;
  assign inst_pc   = inst_valid ? buf_head.pc   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      // accept is already 0 in a redirect cycle.
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (redirect_valid) begin
        pc       <= {redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // PCs of issued requests; popped by every response, stale or not, so it is
  // never flushed by a redirect.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (pc),
    .pop   (imem_rvalid),
    .flush (1'b0),
    .dout  (pcq_head),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .din   (buf_in),
    .pop   (xfer),
    .flush (redirect_valid),
    .dout  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Status outputs the credit scheme makes redundant here.
  logic unused_status;
  assign unused_status = &{1'b0, pcq_count, pcq_full, pcq_empty, buf_full,
                           redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] SIG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_code;
  logic [31:0] w_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // Second instance starting at the top of the address space; it never gets
  // responses, so it issues exactly two requests and then runs out of credit.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ready     (1'b1),
    .imem_rvalid    (1'b0),
    .imem_rdata     (32'h0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .inst_valid     (w_valid),
    .inst_code      (w_code),
    .inst_pc        (w_pc),
    .inst_ready     (1'b0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  int          n_xfer = 0;
  int          n_acc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic        prev_hold;
  logic        prev_redir;
  logic [31:0] prev_pc;
  logic [31:0] prev_code;
  logic [31:0] redir_target;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle. Entered just after a falling edge with the caller's
  // inputs set; drives the memory response, samples, advances to next falling edge.
  task automatic cycle();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].addr ^ SIG;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (prev_redir) begin
      check("valid_after_redirect", 32'(inst_valid), 32'd0);
      check("addr_after_redirect", imem_addr, redir_target);
    end
    if (prev_hold) begin
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_pc", inst_pc, prev_pc);
      check("hold_code", inst_code, prev_code);
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      check("xfer_pc", inst_pc, exp_pc);
      check("xfer_code", inst_code, exp_pc ^ SIG);
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (redirect_valid) begin
      check("req_in_redirect", 32'(imem_req), 32'd0);
      exp_pc    = redirect_pc & 32'hFFFF_FFFC;
      exp_fetch = exp_pc;
    end
    if (imem_rvalid) void'(mem_q.pop_front());
    if (imem_req && imem_ready) begin
      check("fetch_addr", imem_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      mem_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      n_acc++;
    end
    prev_hold    = inst_valid && !inst_ready && !redirect_valid;
    prev_pc      = inst_pc;
    prev_code    = inst_code;
    prev_redir   = redirect_valid;
    redir_target = redirect_pc & 32'hFFFF_FFFC;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the asynchronous response, clears the
  // memory model and reference, and releases on a falling edge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_code", inst_code, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    mem_q.delete();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    exp_pc         = 32'h0;
    exp_fetch      = 32'h0;
    prev_hold      = 1'b0;
    prev_redir     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int a0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    @(negedge clk);
    apply_reset();

    // Streaming with a 1-cycle memory: one instruction per cycle.
    lat_min = 1; lat_max = 1;
    imem_ready = 1'b1;
    inst_ready = 1'b1;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    n0 = n_xfer;
    cycle();
    check("wrap_second_req", 32'(w_req), 32'd1);
    check("wrap_second_addr", w_addr, 32'h0000_0000);
    cycle();
    check("wrap_no_credit", 32'(w_req), 32'd0);
    for (int i = 0; i < 20; i++) cycle();
    check("throughput", 32'(n_xfer - n0), 32'd20);

    // Decode stalled: two fetches then no credit; both delivered in order.
    apply_reset();
    inst_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) cycle();
    check("stall_accepts", 32'(n_acc - a0), 32'd2);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(inst_valid), 32'd1);
    check("stall_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    n0 = n_xfer;
    for (int i = 0; i < 6; i++) cycle();
    check("stall_release_xfers", 32'(n_xfer - n0), 32'd6);

    // 3-cycle memory, redirect with two requests outstanding.
    apply_reset();
    lat_min = 3; lat_max = 3;
    cycle();
    cycle();
    check("two_outstanding_no_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    n0 = n_xfer;
    for (int i = 0; i < 20 && n_xfer == n0; i++) cycle();
    check("redirect_stream_resumed", 32'(n_xfer > n0), 32'd1);

    // Redirect coincident with a response and a ready transfer; unaligned target.
    apply_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) cycle();
    check("coincident_setup",
          32'(inst_valid && mem_q.size() > 0 && mem_q[0].due <= cyc), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    n0 = n_xfer;
    cycle();
    redirect_valid = 1'b0;
    check("no_xfer_in_redirect", 32'(n_xfer - n0), 32'd0);
    check("aligned_redirect_addr", imem_addr, 32'h0000_0200);
    for (int i = 0; i < 6; i++) cycle();
    check("redirect_target_delivered", 32'(n_xfer - n0 > 0), 32'd1);

    // Randomized traffic with a mid-operation reset.
    apply_reset();
    lat_min = 1; lat_max = 4;
    n0 = n_xfer;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset();
      imem_ready     = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(19, 0) == 0);
      case ($urandom_range(3, 0))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        2:       redirect_pc = 32'($urandom_range(255, 0));
        default: redirect_pc = 32'h8000_0000 | 32'($urandom_range(4095, 0));
      endcase
      cycle();
    end
    redirect_valid = 1'b0;
    check("random_progress", 32'(n_xfer - n0 > 50), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
